// File: rtl/cpu_read_bank.sv
// CPU read-side register bank: edge-detected FIFO pops, atomic channel
// snapshot, sticky read-to-clear status and a saturating underflow counter.
module cpu_read_bank #(
    parameter int ADDR_W      = 9,
    parameter int NUM_FIFO    = 2,
    parameter int NUM_CH      = 12,
    parameter int CH_BASE     = 50,
    parameter int STAT_ADDR   = 8,
    parameter int SNAP_ADDR   = 9,
    parameter int ERR_ADDR    = 10,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16   // width of err_cnt and snap_seq (2..16)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cpu_rd_n,
    input  logic [ADDR_W-1:0]        cpu_addr,
    output logic [31:0]              cpu_rdata,
    input  logic [NUM_FIFO*16-1:0]   fifo_usedw,
    input  logic [NUM_FIFO*32-1:0]   fifo_data,
    input  logic [NUM_FIFO-1:0]      fifo_empty,
    output logic [NUM_FIFO-1:0]      fifo_ack,
    input  logic [NUM_CH*32-1:0]     ch_data,
    input  logic [15:0]              status_in
);

    logic [SYNC_STAGES-1:0][NUM_CH*32-1:0] ch_pipe;
    logic [SYNC_STAGES-1:0][15:0]          stat_pipe;
    logic [NUM_CH*32-1:0]                  ch_sync;
    logic [15:0]                           status_sync;

    logic [NUM_CH-1:0][31:0] snap;
    logic [CNT_W-1:0]        snap_seq;
    logic [CNT_W-1:0]        snap_seq_inc;
    logic [CNT_W-1:0]        err_cnt;
    logic [15:0]             sticky;
    logic                    rd_n_q;
    logic                    rd_start;

    logic [31:0]             addr32;
    logic [31:0]             mux_val;
    logic [31:0]             rd_val;
    logic [NUM_FIFO-1:0]     data_hit;
    logic [NUM_FIFO-1:0]     pop;
    logic                    stat_hit;
    logic                    snap_hit;
    logic                    err_hit;
    logic                    underflow;

    assign ch_sync      = ch_pipe[SYNC_STAGES-1];
    assign status_sync  = stat_pipe[SYNC_STAGES-1];
    assign addr32       = 32'(cpu_addr);
    assign snap_seq_inc = snap_seq + CNT_W'(1);

    // Reset to 0 so a strobe already low when reset releases never starts a read.
    assign rd_start  = rd_n_q & ~cpu_rd_n;
    assign pop       = data_hit & ~fifo_empty & {NUM_FIFO{rd_start}};
    assign underflow = rd_start & |(data_hit & fifo_empty);

    // Resynchronise the asynchronous telemetry and status inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ch_pipe   <= '0;
            stat_pipe <= '0;
        end else begin
            ch_pipe[0]   <= ch_data;
            stat_pipe[0] <= status_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                ch_pipe[s]   <= ch_pipe[s-1];
                stat_pipe[s] <= stat_pipe[s-1];
            end
        end
    end

    // Address decode and read mux; fixed registers are decoded last so they win overlaps.
    always_comb begin
        mux_val  = '0;
        data_hit = '0;
        stat_hit = 1'b0;
        snap_hit = 1'b0;
        err_hit  = 1'b0;
        for (int i = 0; i < NUM_CH; i++)
            if (addr32 == 32'(CH_BASE + i)) mux_val = snap[i];
        for (int k = 0; k < NUM_FIFO; k++) begin
            if (addr32 == 32'(2 * k)) mux_val = {16'd0, fifo_usedw[16*k +: 16]};
            if (addr32 == 32'(2 * k + 1)) begin
                mux_val     = fifo_data[32*k +: 32];
                data_hit[k] = 1'b1;
            end
        end
        if (addr32 == 32'(STAT_ADDR)) begin
            mux_val  = {16'd0, sticky | status_sync};
            stat_hit = 1'b1;
        end
        if (addr32 == 32'(SNAP_ADDR)) begin
            mux_val  = 32'(snap_seq);
            snap_hit = 1'b1;
        end
        if (addr32 == 32'(ERR_ADDR)) begin
            mux_val = 32'(err_cnt);
            err_hit = 1'b1;
        end
        if (stat_hit || snap_hit || err_hit) data_hit = '0;
    end

    // Side effects of a read change what is returned at the start of the strobe.
    always_comb begin
        rd_val = mux_val;
        if (rd_start && snap_hit) rd_val = 32'(snap_seq_inc);
        if (underflow)            rd_val = '0;
    end

    // Strobe edge detect and read data register, held while the strobe is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_n_q    <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            rd_n_q <= cpu_rd_n;
            if (cpu_rd_n || rd_start) cpu_rdata <= rd_val;
        end
    end

    // One pop pulse per read of a non-empty FIFO data address.
    always_ff @(posedge clk) begin
        if (!rst_n) fifo_ack <= '0;
        else        fifo_ack <= pop;
    end

    // Sticky status accumulates; a status read keeps only what is arriving now.
    always_ff @(posedge clk) begin
        if (!rst_n)                    sticky <= '0;
        else if (rd_start && stat_hit) sticky <= status_sync;
        else                           sticky <= sticky | status_sync;
    end

    // Atomic snapshot of all channels plus sequence number.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            snap     <= '0;
            snap_seq <= '0;
        end else if (rd_start && snap_hit) begin
            snap     <= ch_sync;
            snap_seq <= snap_seq_inc;
        end
    end

    // Underflow counter: saturating, cleared by reading it.
    always_ff @(posedge clk) begin
        if (!rst_n)                      err_cnt <= '0;
        else if (rd_start && err_hit)    err_cnt <= '0;
        else if (underflow && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_cpu_read_bank.sv
// Scoreboard bench for cpu_read_bank. Counters are built 8 bits wide so
// saturation and wrap are reachable in a short run.
module tb_cpu_read_bank;

    localparam int CW = 8;
    localparam logic [CW-1:0] CMAX = '1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_rd_n;
    logic [8:0]  cpu_addr;
    logic [31:0] cpu_rdata;
    logic [31:0] fifo_usedw;
    logic [63:0] fifo_data;
    logic [1:0]  fifo_empty;
    logic [1:0]  fifo_ack;
    logic [383:0] ch_data;
    logic [15:0] status_in;

    logic [31:0]   exp_q[$];
    logic [31:0]   exp;
    logic [CW-1:0] seq_model;
    logic [CW-1:0] err_model;
    int n_checks = 0;
    int n_fail   = 0;

    cpu_read_bank #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_rd_n(cpu_rd_n), .cpu_addr(cpu_addr),
        .cpu_rdata(cpu_rdata), .fifo_usedw(fifo_usedw), .fifo_data(fifo_data),
        .fifo_empty(fifo_empty), .fifo_ack(fifo_ack), .ch_data(ch_data),
        .status_in(status_in)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns #1 after the edge on which the read starts.
    task automatic start_read(input logic [8:0] a);
        @(posedge clk); #1;
        cpu_addr = a;
        cpu_rd_n = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic end_read();
        cpu_rd_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        n_checks++;
        if (cpu_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", cpu_rdata); end
        n_checks++;
        if (fifo_ack !== 2'b00) begin n_fail++; $display("FAIL reset_ack: got %b want 00", fifo_ack); end
        rst_n = 1'b1;
        tick(2);
        exp_q.push_back(32'd0);
        start_read(9'd8);
        exp = exp_q.pop_front(); n_checks++;
        if (cpu_rdata !== exp) begin n_fail++; $display("FAIL reset_stat: got %h want %h", cpu_rdata, exp); end
        end_read();
        exp_q.push_back(32'd0);
        start_read(9'd10);
        exp = exp_q.pop_front(); n_checks++;
        if (cpu_rdata !== exp) begin n_fail++; $display("FAIL reset_err: got %h want %h", cpu_rdata, exp); end
        end_read();
    endtask

    task automatic test_fifo_pop();
        int acks;
        fifo_data[31:0]  = 32'hA5A5_0001;
        fifo_usedw[15:0] = 16'd7;
        fifo_empty[0]    = 1'b0;
        exp_q.push_back(32'd7);
        start_read(9'd0);
        exp = exp_q.pop_front(); n_checks++;
        if (cpu_rdata !== exp) begin n_fail++; $display("FAIL usedw0: got %h want %h", cpu_rdata, exp); end
        n_checks++;
        if (fifo_ack !== 2'b00) begin n_fail++; $display("FAIL usedw_no_ack: got %b want 00", fifo_ack); end
        end_read();
        exp_q.push_back(32'd0);
        start_read(9'd20);
        exp = exp_q.pop_front(); n_checks++;
        if (cpu_rdata !== exp) begin n_fail++; $display("FAIL unmapped: got %h want %h", cpu_rdata, exp); end
        end_read();
        exp_q.push_back(32'hA5A5_0001);
        start_read(9'd1);
        exp = exp_q.pop_front();
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) tick(1);
            if (fifo_ack[0]) acks++;
            n_checks++;
            if (cpu_rdata !== exp) begin n_fail++; $display("FAIL pop_hold c%0d: got %h want %h", c, cpu_rdata, exp); end
            if (c == 0) begin
                n_checks++;
                if (fifo_ack !== 2'b01) begin n_fail++; $display("FAIL pop_pulse: got %b want 01", fifo_ack); end
                fifo_data[31:0] = 32'hA5A5_0002;  // FIFO advanced its head
            end
        end
        n_checks++;
        if (acks != 1) begin n_fail++; $display("FAIL pop_count: got %0d want 1", acks); end
        end_read();
        n_checks++;
        if (fifo_ack !== 2'b00) begin n_fail++; $display("FAIL pop_after: got %b want 00", fifo_ack); end
    endtask

    task automatic test_underflow();
        fifo_empty[1]    = 1'b1;
        fifo_data[63:32] = 32'hDEAD_BEEF;
        err_model = '0;
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(32'd0);
            start_read(9'd3);
            exp = exp_q.pop_front(); n_checks++;
            if (cpu_rdata !== exp) begin n_fail++; $display("FAIL uflow_data r%0d: got %h want %h", r, cpu_rdata, exp); end
            n_checks++;
            if (fifo_ack[1] !== 1'b0) begin n_fail++; $display("FAIL uflow_ack r%0d: got %b want 0", r, fifo_ack[1]); end
            end_read();
            if (err_model != CMAX) err_model++;
        end
        exp_q.push_back(32'(err_model));
        start_read(9'd10);
        exp = exp_q.pop_front(); n_checks++;
        if (cpu_rdata !== exp) begin n_fail++; $display("FAIL err_count: got %h want %h", cpu_rdata, exp); end
        end_read();
        err_model = '0;
        exp_q.push_back(32'(err_model));
        start_read(9'd10);
        exp = exp_q.pop_front(); n_checks++;
        if (cpu_rdata !== exp) begin n_fail++; $display("FAIL err_clear: got %h want %h", cpu_rdata, exp); end
        end_read();
        for (int r = 0; r < 300; r++) begin
            start_read(9'd3);
            end_read();
            if (err_model != CMAX) err_model++;
        end
        exp_q.push_back(32'(err_model));
        start_read(9'd10);
        exp = exp_q.pop_front(); n_checks++;
        if (cpu_rdata !== exp) begin n_fail++; $display("FAIL err_saturate: got %h want %h", cpu_rdata, exp); end
        end_read();
    endtask

    task automatic test_snapshot();
        ch_data[3*32 +: 32]  = 32'h0000_1234;
        ch_data[11*32 +: 32] = 32'hCAFE_0011;
        tick(4);
        seq_model = '0;
        seq_model++;
        exp_q.push_back(32'(seq_model));
        start_read(9'd9);
        exp = exp_q.pop_front(); n_checks++;
        if (cpu_rdata !== exp) begin n_fail++; $display("FAIL snap_seq1: got %h want %h", cpu_rdata, exp); end
        end_read();
        ch_data[3*32 +: 32] = 32'h0000_9999;
        tick(4);
        exp_q.push_back(32'h0000_1234);
        start_read(9'd53);
        exp = exp_q.pop_front(); n_checks++;
        if (cpu_rdata !== exp) begin n_fail++; $display("FAIL snap_ch3_old: got %h want %h", cpu_rdata, exp); end
        end_read();
        exp_q.push_back(32'hCAFE_0011);
        start_read(9'd61);
        exp = exp_q.pop_front(); n_checks++;
        if (cpu_rdata !== exp) begin n_fail++; $display("FAIL snap_ch11: got %h want %h", cpu_rdata, exp); end
        end_read();
        seq_model++;
        exp_q.push_back(32'(seq_model));
        start_read(9'd9);
        exp = exp_q.pop_front(); n_checks++;
        if (cpu_rdata !== exp) begin n_fail++; $display("FAIL snap_seq2: got %h want %h", cpu_rdata, exp); end
        end_read();
        exp_q.push_back(32'h0000_9999);
        start_read(9'd53);
        exp = exp_q.pop_front(); n_checks++;
        if (cpu_rdata !== exp) begin n_fail++; $display("FAIL snap_ch3_new: got %h want %h", cpu_rdata, exp); end
        end_read();
    endtask

    task automatic test_sticky();
        @(posedge clk); #1;
        status_in = 16'h0020;
        tick(1);
        status_in = 16'h0000;
        tick(4);
        exp_q.push_back(32'h20);
        exp_q.push_back(32'h00);
        for (int r = 0; r < 2; r++) begin
            start_read(9'd8);
            exp = exp_q.pop_front(); n_checks++;
            if (cpu_rdata !== exp) begin n_fail++; $display("FAIL sticky_pulse r%0d: got %h want %h", r, cpu_rdata, exp); end
            end_read();
        end
        status_in = 16'h0004;
        tick(4);
        exp_q.push_back(32'h04);
        start_read(9'd8);
        exp = exp_q.pop_front(); n_checks++;
        if (cpu_rdata !== exp) begin n_fail++; $display("FAIL sticky_live: got %h want %h", cpu_rdata, exp); end
        end_read();
        status_in = 16'h0000;
        tick(4);
        exp_q.push_back(32'h04);
        exp_q.push_back(32'h00);
        for (int r = 0; r < 2; r++) begin
            start_read(9'd8);
            exp = exp_q.pop_front(); n_checks++;
            if (cpu_rdata !== exp) begin n_fail++; $display("FAIL sticky_kept r%0d: got %h want %h", r, cpu_rdata, exp); end
            end_read();
        end
    endtask

    task automatic test_seq_wrap();
        while (seq_model != CMAX - 1) begin
            start_read(9'd9);
            end_read();
            seq_model++;
        end
        for (int r = 0; r < 2; r++) begin
            seq_model++;
            exp_q.push_back(32'(seq_model));
            start_read(9'd9);
            exp = exp_q.pop_front(); n_checks++;
            if (cpu_rdata !== exp) begin n_fail++; $display("FAIL seq_wrap r%0d: got %h want %h", r, cpu_rdata, exp); end
            end_read();
        end
    endtask

    task automatic test_reset_mid_strobe();
        int acks;
        fifo_empty[0]   = 1'b0;
        fifo_data[31:0] = 32'hA5A5_0003;
        start_read(9'd3);                   // leave one underflow pending in err_cnt
        end_read();
        start_read(9'd1);
        n_checks++;
        if (fifo_ack !== 2'b01) begin n_fail++; $display("FAIL rst_pre_ack: got %b want 01", fifo_ack); end
        rst_n = 1'b0;
        tick(1);
        n_checks++;
        if (fifo_ack !== 2'b00) begin n_fail++; $display("FAIL rst_ack: got %b want 00", fifo_ack); end
        n_checks++;
        if (cpu_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", cpu_rdata); end
        tick(1);
        rst_n = 1'b1;
        acks = 0;
        for (int c = 0; c < 4; c++) begin
            tick(1);
            if (fifo_ack != 2'b00) acks++;
        end
        n_checks++;
        if (acks != 0) begin n_fail++; $display("FAIL rst_strobe_ignored: got %0d acks want 0", acks); end
        end_read();
        exp_q.push_back(32'hA5A5_0003);
        start_read(9'd1);
        exp = exp_q.pop_front(); n_checks++;
        if (cpu_rdata !== exp) begin n_fail++; $display("FAIL rst_new_read: got %h want %h", cpu_rdata, exp); end
        n_checks++;
        if (fifo_ack !== 2'b01) begin n_fail++; $display("FAIL rst_new_ack: got %b want 01", fifo_ack); end
        end_read();
        exp_q.push_back(32'd0);
        start_read(9'd10);
        exp = exp_q.pop_front(); n_checks++;
        if (cpu_rdata !== exp) begin n_fail++; $display("FAIL rst_err: got %h want %h", cpu_rdata, exp); end
        end_read();
        exp_q.push_back(32'd1);
        start_read(9'd9);
        exp = exp_q.pop_front(); n_checks++;
        if (cpu_rdata !== exp) begin n_fail++; $display("FAIL rst_seq: got %h want %h", cpu_rdata, exp); end
        end_read();
    endtask

    initial begin
        rst_n      = 1'b0;
        cpu_rd_n   = 1'b1;
        cpu_addr   = '0;
        fifo_usedw = '0;
        fifo_data  = '0;
        fifo_empty = 2'b11;
        ch_data    = '0;
        status_in  = '0;
        test_reset();
        test_fifo_pop();
        test_underflow();
        test_snapshot();
        test_sticky();
        test_seq_wrap();
        test_reset_mid_strobe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
